// File: rtl/experiment_shot_sequencer.sv
// rtl/experiment_shot_sequencer.sv - host-side shot sequencer driving the experiment-phase FSM
//
// Runs a programmed number of shots back to back against the phase FSM. For each shot it
// holds exp_start high until the FSM reports ST_FINISHED. It then releases exp_start, waits
// for the FSM to return to ST_IDLE, and observes a cooldown. A per-phase watchdog (and host
// abort) recovers a hung FSM by pulsing exp_reset.
//
// Ports:
//   clock, reset_signal   clock and asynchronous active-low reset
//   arm, abort            1-cycle host pulses: start a run / stop the run
//   num_shots[15:0]       shots per run, latched on the accepted arm
//   exp_state[7:0]        scenario_state from the phase FSM
//   exp_start, exp_reset  start level and recovery reset pulse to the phase FSM
//   busy, done, error     status: not idle / end-of-run pulse / sticky timeout flag
//   shots_done, timeouts  per-run counters (saturating)
//   seq_state[2:0]        current sequencer state code
module experiment_shot_sequencer #(
    parameter int         SHOT_TIMEOUT    = 50_000_000,
    parameter int         COOLDOWN        = 20_000_000,
    parameter int         RESET_PULSE_LEN = 4,
    parameter logic [7:0] ST_IDLE         = 8'd0,
    parameter logic [7:0] ST_FINISHED     = 8'd10,
    parameter bit         STOP_ON_TIMEOUT = 1'b1
) (
    input  logic        clock,
    input  logic        reset_signal,
    input  logic        arm,
    input  logic        abort,
    input  logic [15:0] num_shots,
    input  logic [7:0]  exp_state,
    output logic        exp_start,
    output logic        exp_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] shots_done,
    output logic [15:0] timeouts,
    output logic [2:0]  seq_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_RELEASE  = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;
    localparam logic [2:0] S_RECOVER  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [31:0] WD_LAST      = 32'(SHOT_TIMEOUT - 1);
    localparam logic [31:0] CD_LAST      = 32'(COOLDOWN - 1);
    localparam logic [31:0] PULSE_LEN    = 32'(RESET_PULSE_LEN);
    // Recovery gives up waiting for ST_IDLE one full watchdog period after the pulse ends.
    localparam logic [31:0] RECOVER_LAST = 32'(RESET_PULSE_LEN + SHOT_TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [31:0] tmr;
    logic [15:0] shot_count;
    logic        abort_trig;

    logic        accept_arm;
    logic        inc_shot;
    logic        inc_timeout;
    logic        take_abort;
    logic        in_shot;
    logic [16:0] settled;

    assign seq_state = state;
    assign in_shot   = (state == S_START) || (state == S_RUN) || (state == S_RELEASE);
    // Shots that are finished either way; a timed-out shot still consumes one of the count.
    assign settled   = {1'b0, shots_done} + {1'b0, timeouts};

    always_comb begin
        next_state  = state;
        accept_arm  = 1'b0;
        inc_shot    = 1'b0;
        inc_timeout = 1'b0;
        take_abort  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    accept_arm = 1'b1;
                    next_state = (num_shots == 16'd0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                if (exp_state != ST_IDLE) next_state = S_RUN;
            end
            S_RUN: begin
                if (exp_state == ST_FINISHED) begin
                    inc_shot   = 1'b1;
                    next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (exp_state == ST_IDLE)
                    next_state = (settled < {1'b0, shot_count}) ? S_COOLDOWN : S_DONE;
            end
            S_COOLDOWN: begin
                if (tmr == CD_LAST) next_state = S_START;
            end
            S_RECOVER: begin
                if (tmr >= PULSE_LEN) begin
                    if (exp_state == ST_IDLE) begin
                        if (abort_trig || STOP_ON_TIMEOUT || (settled >= {1'b0, shot_count}))
                            next_state = S_DONE;
                        else
                            next_state = S_COOLDOWN;
                    end else if (tmr == RECOVER_LAST) begin
                        next_state = S_DONE;
                    end
                end
            end
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase

        // Watchdog overrides any normal transition; a shot that times out is never counted.
        if (in_shot && (tmr == WD_LAST)) begin
            next_state  = S_RECOVER;
            inc_shot    = 1'b0;
            inc_timeout = 1'b1;
        end

        if (abort && (in_shot || (state == S_COOLDOWN))) begin
            next_state  = S_RECOVER;
            inc_shot    = 1'b0;
            inc_timeout = 1'b0;
            take_abort  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_signal) begin
        if (!reset_signal) begin
            state      <= S_IDLE;
            tmr        <= 32'd0;
            shot_count <= 16'd0;
            abort_trig <= 1'b0;
            shots_done <= 16'd0;
            timeouts   <= 16'd0;
            error      <= 1'b0;
            exp_start  <= 1'b0;
            exp_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state != state) || (state == S_IDLE))
                tmr <= 32'd0;
            else
                tmr <= tmr + 32'd1;

            if (accept_arm) begin
                shot_count <= num_shots;
                shots_done <= 16'd0;
                timeouts   <= 16'd0;
                error      <= 1'b0;
                abort_trig <= 1'b0;
            end
            if (inc_shot && (shots_done != 16'hFFFF))
                shots_done <= shots_done + 16'd1;
            if (inc_timeout) begin
                error <= 1'b1;
                if (timeouts != 16'hFFFF) timeouts <= timeouts + 16'd1;
            end
            if (take_abort)
                abort_trig <= 1'b1;

            // FSM-facing strobes follow the state one cycle later.
            exp_start <= (state == S_START) || (state == S_RUN);
            exp_reset <= (state == S_RECOVER) && (tmr < PULSE_LEN);
            done      <= (state == S_DONE);
            busy      <= (next_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_experiment_shot_sequencer.sv
// tb/tb_experiment_shot_sequencer.sv - directed self-checking bench for experiment_shot_sequencer
module tb_experiment_shot_sequencer;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        arm_a, arm_b, abort_a, abort_b;
    logic [15:0] num_shots;
    logic [7:0]  st_a, st_b;
    logic        exp_start_a, exp_reset_a, busy_a, done_a, error_a;
    logic        exp_start_b, exp_reset_b, busy_b, done_b, error_b;
    logic [15:0] shots_done_a, timeouts_a, shots_done_b, timeouts_b;
    logic [2:0]  seq_state_a, seq_state_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    experiment_shot_sequencer #(
        .SHOT_TIMEOUT(100), .COOLDOWN(10), .RESET_PULSE_LEN(4),
        .ST_IDLE(8'd0), .ST_FINISHED(8'd10), .STOP_ON_TIMEOUT(1'b1)
    ) dut_a (
        .clock(clock), .reset_signal(rst_n), .arm(arm_a), .abort(abort_a),
        .num_shots(num_shots), .exp_state(st_a), .exp_start(exp_start_a),
        .exp_reset(exp_reset_a), .busy(busy_a), .done(done_a), .error(error_a),
        .shots_done(shots_done_a), .timeouts(timeouts_a), .seq_state(seq_state_a)
    );

    experiment_shot_sequencer #(
        .SHOT_TIMEOUT(100), .COOLDOWN(10), .RESET_PULSE_LEN(4),
        .ST_IDLE(8'd0), .ST_FINISHED(8'd10), .STOP_ON_TIMEOUT(1'b0)
    ) dut_b (
        .clock(clock), .reset_signal(rst_n), .arm(arm_b), .abort(abort_b),
        .num_shots(num_shots), .exp_state(st_b), .exp_start(exp_start_b),
        .exp_reset(exp_reset_b), .busy(busy_b), .done(done_b), .error(error_b),
        .shots_done(shots_done_b), .timeouts(timeouts_b), .seq_state(seq_state_b)
    );

    // Phase FSM models: leave 0 on start, walk 1..10, return to 0 once start drops.
    // A shot whose start index is below hang_until_* sticks at state 3 until exp_reset.
    int   starts_a = 0, starts_b = 0;
    int   hang_until_a = 0, hang_until_b = 0;
    logic hanging_a, hanging_b;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            st_a <= 8'd0; starts_a <= 0; hanging_a <= 1'b0;
        end else if (exp_reset_a) begin
            st_a <= 8'd0; hanging_a <= 1'b0;
        end else if (st_a == 8'd0) begin
            if (exp_start_a) begin
                st_a <= 8'd1; starts_a <= starts_a + 1; hanging_a <= (starts_a < hang_until_a);
            end
        end else if (st_a == 8'd10) begin
            if (!exp_start_a) st_a <= 8'd0;
        end else if (!(hanging_a && st_a == 8'd3)) begin
            st_a <= st_a + 8'd1;
        end
    end

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            st_b <= 8'd0; starts_b <= 0; hanging_b <= 1'b0;
        end else if (exp_reset_b) begin
            st_b <= 8'd0; hanging_b <= 1'b0;
        end else if (st_b == 8'd0) begin
            if (exp_start_b) begin
                st_b <= 8'd1; starts_b <= starts_b + 1; hanging_b <= (starts_b < hang_until_b);
            end
        end else if (st_b == 8'd10) begin
            if (!exp_start_b) st_b <= 8'd0;
        end else if (!(hanging_b && st_b == 8'd3)) begin
            st_b <= st_b + 8'd1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state_a(input logic [2:0] s, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (seq_state_a == s) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm_a = 0; arm_b = 0; abort_a = 0; abort_b = 0; num_shots = 16'd0;
        tick(); tick();
        n_checks++;
        if ({exp_start_a, exp_reset_a, busy_a, done_a, error_a} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                               {exp_start_a, exp_reset_a, busy_a, done_a, error_a});
        end
        n_checks++;
        if ({shots_done_a, timeouts_a, seq_state_a} !== 35'd0) begin
            n_fail++; $display("FAIL reset_counters: got sd=%0d to=%0d st=%0d expected 0",
                               shots_done_a, timeouts_a, seq_state_a);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (seq_state_a !== 3'd0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got st=%0d busy=%b expected 0/0", seq_state_a, busy_a);
        end
    endtask

    task automatic test_normal();
        int rises, last_fall, gap, min_gap, max_gap, fin_age, cyc;
        bit prev, fin_done, saw_done;
        num_shots = 16'd3; arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
        n_checks++;
        if (seq_state_a !== 3'd1 || busy_a !== 1'b1 || exp_start_a !== 1'b0) begin
            n_fail++; $display("FAIL normal_accept: got st=%0d busy=%b start=%b expected 1/1/0",
                               seq_state_a, busy_a, exp_start_a);
        end
        tick();
        n_checks++;
        if (exp_start_a !== 1'b1) begin
            n_fail++; $display("FAIL normal_start_latency: got %b expected 1", exp_start_a);
        end
        rises = 1; prev = 1'b1; last_fall = 0; min_gap = 1000; max_gap = 0;
        fin_age = -1; fin_done = 1'b0; saw_done = 1'b0;
        for (cyc = 0; cyc < 1500; cyc++) begin
            tick();
            if (fin_age >= 0) begin
                fin_age++;
                if (fin_age == 1) begin
                    n_checks++;
                    if (exp_start_a !== 1'b1) begin
                        n_fail++; $display("FAIL finish_hold: got %b expected 1", exp_start_a);
                    end
                end else begin
                    n_checks++;
                    if (exp_start_a !== 1'b0) begin
                        n_fail++; $display("FAIL finish_release_latency: got %b expected 0", exp_start_a);
                    end
                    fin_age = -1; fin_done = 1'b1;
                end
            end else if (!fin_done && st_a == 8'd10) begin
                fin_age = 0;
            end
            if (exp_start_a && !prev) begin
                rises++;
                gap = cyc - last_fall;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end
            if (!exp_start_a && prev) last_fall = cyc;
            prev = exp_start_a;
            if (done_a) begin saw_done = 1'b1; break; end
        end
        n_checks++;
        if (!saw_done) begin
            n_fail++; $display("FAIL normal_done: no done pulse within 1500 cycles");
        end
        n_checks++;
        if (rises !== 3) begin
            n_fail++; $display("FAIL normal_start_periods: got %0d expected 3", rises);
        end
        n_checks++;
        if (min_gap !== 13 || max_gap !== 13) begin
            n_fail++; $display("FAIL normal_gap: got min=%0d max=%0d expected 13", min_gap, max_gap);
        end
        n_checks++;
        if (shots_done_a !== 16'd3 || error_a !== 1'b0 || timeouts_a !== 16'd0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL normal_result: got sd=%0d err=%b to=%0d busy=%b expected 3/0/0/0",
                               shots_done_a, error_a, timeouts_a, busy_a);
        end
        tick();
        n_checks++;
        if (done_a !== 1'b0) begin
            n_fail++; $display("FAIL normal_done_width: got %b expected 0", done_a);
        end
    endtask

    task automatic test_zero_shots();
        num_shots = 16'd0; arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
        n_checks++;
        if (seq_state_a !== 3'd6 || done_a !== 1'b0 || exp_start_a !== 1'b0) begin
            n_fail++; $display("FAIL zero_first: got st=%0d done=%b start=%b expected 6/0/0",
                               seq_state_a, done_a, exp_start_a);
        end
        tick();
        n_checks++;
        if (done_a !== 1'b1 || seq_state_a !== 3'd0 || exp_start_a !== 1'b0 || shots_done_a !== 16'd0) begin
            n_fail++; $display("FAIL zero_done: got done=%b st=%0d start=%b sd=%0d expected 1/0/0/0",
                               done_a, seq_state_a, exp_start_a, shots_done_a);
        end
        tick();
        n_checks++;
        if (done_a !== 1'b0 || exp_start_a !== 1'b0) begin
            n_fail++; $display("FAIL zero_after: got done=%b start=%b expected 0/0", done_a, exp_start_a);
        end
    endtask

    task automatic test_hang();
        bit ok;
        int run_cycles, rst_cycles;
        hang_until_a = starts_a + 1;
        num_shots = 16'd3; arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
        wait_state_a(3'd2, 50, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL hang_reach_run: state 2 not reached in 50 cycles");
        end
        run_cycles = 1;
        for (int i = 0; i < 200 && seq_state_a == 3'd2; i++) begin
            tick();
            if (seq_state_a == 3'd2) run_cycles++;
        end
        n_checks++;
        if (run_cycles !== 100 || seq_state_a !== 3'd5) begin
            n_fail++; $display("FAIL hang_watchdog: got %0d cycles in RUN then st=%0d expected 100 then 5",
                               run_cycles, seq_state_a);
        end
        tick();
        n_checks++;
        if (exp_start_a !== 1'b0 || exp_reset_a !== 1'b1) begin
            n_fail++; $display("FAIL hang_recover_outputs: got start=%b reset=%b expected 0/1",
                               exp_start_a, exp_reset_a);
        end
        rst_cycles = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_reset_a) rst_cycles++;
            if (done_a) break;
        end
        n_checks++;
        if (rst_cycles !== 4 || done_a !== 1'b1) begin
            n_fail++; $display("FAIL hang_reset_pulse: got %0d reset cycles done=%b expected 4/1",
                               rst_cycles, done_a);
        end
        n_checks++;
        if (timeouts_a !== 16'd1 || error_a !== 1'b1 || shots_done_a !== 16'd0) begin
            n_fail++; $display("FAIL hang_counters: got to=%0d err=%b sd=%0d expected 1/1/0",
                               timeouts_a, error_a, shots_done_a);
        end
        hang_until_a = 0;
    endtask

    task automatic test_hang_continue();
        int base;
        bit saw_done;
        base = starts_b;
        hang_until_b = starts_b + 1;
        num_shots = 16'd2; arm_b = 1'b1;
        tick();
        arm_b = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (done_b) begin saw_done = 1'b1; break; end
        end
        n_checks++;
        if (!saw_done) begin
            n_fail++; $display("FAIL continue_done: no done pulse within 2000 cycles");
        end
        n_checks++;
        if (shots_done_b !== 16'd1 || timeouts_b !== 16'd1 || error_b !== 1'b1) begin
            n_fail++; $display("FAIL continue_counters: got sd=%0d to=%0d err=%b expected 1/1/1",
                               shots_done_b, timeouts_b, error_b);
        end
        n_checks++;
        if (starts_b - base !== 2 || busy_b !== 1'b0 || seq_state_b !== 3'd0) begin
            n_fail++; $display("FAIL continue_shots: got %0d starts busy=%b st=%0d expected 2/0/0",
                               starts_b - base, busy_b, seq_state_b);
        end
        hang_until_b = 0;
    endtask

    task automatic test_abort();
        bit ok;
        int rst_cycles;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        tick();
        n_checks++;
        if (seq_state_a !== 3'd0 || exp_reset_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle_ignored: got st=%0d reset=%b done=%b expected 0/0/0",
                               seq_state_a, exp_reset_a, done_a);
        end
        num_shots = 16'd3; arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (shots_done_a == 16'd1 && seq_state_a == 3'd2) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL abort_reach_second_shot: not in RUN with 1 shot within 300 cycles");
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        n_checks++;
        if (seq_state_a !== 3'd5 || shots_done_a !== 16'd1) begin
            n_fail++; $display("FAIL abort_recover: got st=%0d sd=%0d expected 5/1", seq_state_a, shots_done_a);
        end
        rst_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_reset_a) rst_cycles++;
            if (done_a) break;
        end
        n_checks++;
        if (rst_cycles !== 4 || done_a !== 1'b1) begin
            n_fail++; $display("FAIL abort_reset_pulse: got %0d reset cycles done=%b expected 4/1",
                               rst_cycles, done_a);
        end
        n_checks++;
        if (shots_done_a !== 16'd1 || timeouts_a !== 16'd0 || error_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_counters: got sd=%0d to=%0d err=%b expected 1/0/0",
                               shots_done_a, timeouts_a, error_a);
        end
    endtask

    task automatic test_async_reset();
        bit ok, stray_done;
        num_shots = 16'd3; arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
        wait_state_a(3'd4, 300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL areset_reach_cooldown: state 4 not reached in 300 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_a, exp_start_a, seq_state_a, shots_done_a} !== 21'd0) begin
            n_fail++; $display("FAIL areset_immediate: got busy=%b start=%b st=%0d sd=%0d expected 0",
                               busy_a, exp_start_a, seq_state_a, shots_done_a);
        end
        tick();
        rst_n = 1'b1;
        stray_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done_a) stray_done = 1'b1;
        end
        n_checks++;
        if (stray_done !== 1'b0) begin
            n_fail++; $display("FAIL areset_no_done: got done pulse expected none");
        end
        num_shots = 16'd1; arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_a) break;
        end
        n_checks++;
        if (done_a !== 1'b1 || shots_done_a !== 16'd1) begin
            n_fail++; $display("FAIL areset_rearm: got done=%b sd=%0d expected 1/1", done_a, shots_done_a);
        end
    endtask

    task automatic test_arm_busy();
        int base, n_done;
        base = starts_a;
        num_shots = 16'd2; arm_a = 1'b1; abort_a = 1'b1;
        tick();
        arm_a = 1'b0; abort_a = 1'b0;
        n_checks++;
        if (seq_state_a !== 3'd1) begin
            n_fail++; $display("FAIL arm_beats_abort: got st=%0d expected 1", seq_state_a);
        end
        num_shots = 16'd7;
        n_done = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done_a) begin n_done++; break; end
            arm_a = ((i % 7) == 3);
        end
        arm_a = 1'b0;
        tick(); tick();
        n_checks++;
        if (n_done !== 1 || shots_done_a !== 16'd2 || starts_a - base !== 2) begin
            n_fail++; $display("FAIL arm_busy_ignored: got done=%0d sd=%0d starts=%0d expected 1/2/2",
                               n_done, shots_done_a, starts_a - base);
        end
        n_checks++;
        if (seq_state_a !== 3'd0 || busy_a !== 1'b0 || error_a !== 1'b0) begin
            n_fail++; $display("FAIL arm_busy_final: got st=%0d busy=%b err=%b expected 0/0/0",
                               seq_state_a, busy_a, error_a);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_shots();
        test_hang();
        test_hang_continue();
        test_abort();
        test_async_reset();
        test_arm_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
